// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline stage status in, stall/flush/forward controls out.
interface hazard_ctrl_if;
    logic [4:0] Rs1D;
    logic [4:0] Rs2D;
    logic [4:0] Rs1E;
    logic [4:0] Rs2E;
    logic [4:0] RdE;
    logic [2:0] ResultSrcE;
    logic       PCSrcE;
    logic [4:0] RdM;
    logic [4:0] RdW;
    logic       RegWriteM;
    logic       RegWriteW;
    logic       MemReqM;
    logic       MemReadyM;
    logic       StallF;
    logic       StallD;
    logic       StallE;
    logic       StallM;
    logic       FlushD;
    logic       FlushE;
    logic       FlushW;
    logic [1:0] ForwardAE;
    logic [1:0] ForwardBE;
    logic       MemErr;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
               RdM, RdW, RegWriteM, RegWriteW, MemReqM, MemReadyM,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               ForwardAE, ForwardBE, MemErr
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
               RdM, RdW, RegWriteM, RegWriteW, MemReqM, MemReadyM,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               ForwardAE, ForwardBE, MemErr
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward generation for the 5-stage RV32 pipe, with post-reset
// purge and a data-memory timeout that halts the pipe until reset.
module hazard_ctrl #(
    parameter int unsigned BOOT_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic          CLK,
    input  logic          RST_N,
    hazard_ctrl_if.slave  hif
);

    localparam int unsigned BCNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [BCNT_W-1:0] BOOT_LAST = BCNT_W'(BOOT_CYCLES - 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                mem_err_q, mem_err_d;

    logic       stall_f, stall_d, stall_e, stall_m;
    logic       flush_d, flush_e, flush_w;
    logic [1:0] fwd_a, fwd_b;

    logic       mem_wait;
    logic       load_use;
    logic       m_hit_a, w_hit_a, m_hit_b, w_hit_b;
    logic [1:0] fwd_sel_a, fwd_sel_b;

    assign mem_wait = hif.MemReqM & ~hif.MemReadyM;
    assign load_use = (hif.ResultSrcE == 3'b001) && (hif.RdE != 5'd0) &&
                      ((hif.RdE == hif.Rs1D) || (hif.RdE == hif.Rs2D));

    // Writes to x0 are never forwarded; the M-stage result is the younger one.
    assign m_hit_a   = hif.RegWriteM && (hif.RdM != 5'd0) && (hif.RdM == hif.Rs1E);
    assign w_hit_a   = hif.RegWriteW && (hif.RdW != 5'd0) && (hif.RdW == hif.Rs1E);
    assign m_hit_b   = hif.RegWriteM && (hif.RdM != 5'd0) && (hif.RdM == hif.Rs2E);
    assign w_hit_b   = hif.RegWriteW && (hif.RdW != 5'd0) && (hif.RdW == hif.Rs2E);
    assign fwd_sel_a = m_hit_a ? 2'b10 : (w_hit_a ? 2'b01 : 2'b00);
    assign fwd_sel_b = m_hit_b ? 2'b10 : (w_hit_b ? 2'b01 : 2'b00);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= ST_BOOT;
            bcnt_q    <= '0;
            wcnt_q    <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcnt_q    <= bcnt_d;
            wcnt_q    <= wcnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        wcnt_d    = '0;
        mem_err_d = mem_err_q;
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        stall_e   = 1'b0;
        stall_m   = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        flush_w   = 1'b0;
        fwd_a     = 2'b00;
        fwd_b     = 2'b00;

        case (state_q)
            ST_BOOT: begin
                stall_f = 1'b1;
                flush_d = 1'b1;
                flush_e = 1'b1;
                bcnt_d  = bcnt_q + BCNT_W'(1);
                if (bcnt_q == BOOT_LAST) begin
                    state_d = ST_RUN;
                    bcnt_d  = '0;
                end
            end
            ST_RUN: begin
                fwd_a = fwd_sel_a;
                fwd_b = fwd_sel_b;
                if (mem_wait) begin
                    // E is frozen during the wait, so a taken branch there must not flush yet.
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    stall_m = 1'b1;
                    flush_w = 1'b1;
                    wcnt_d  = wcnt_q + WCNT_W'(1);
                    if (wcnt_q == WAIT_LAST) begin
                        state_d   = ST_HALT;
                        mem_err_d = 1'b1;
                        wcnt_d    = '0;
                    end
                end else if (hif.PCSrcE) begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (load_use) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end
            end
            ST_HALT: begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        // While reset is held the pipe looks like a purge regardless of stale state.
        if (!RST_N) begin
            stall_f = 1'b1;
            stall_d = 1'b0;
            stall_e = 1'b0;
            stall_m = 1'b0;
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_w = 1'b0;
            fwd_a   = 2'b00;
            fwd_b   = 2'b00;
        end
    end

    assign hif.StallF    = stall_f;
    assign hif.StallD    = stall_d;
    assign hif.StallE    = stall_e;
    assign hif.StallM    = stall_m;
    assign hif.FlushD    = flush_d;
    assign hif.FlushE    = flush_e;
    assign hif.FlushW    = flush_w;
    assign hif.ForwardAE = fwd_a;
    assign hif.ForwardBE = fwd_b;
    assign hif.MemErr    = mem_err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expected control vectors are queued as each
// cycle's inputs are driven and compared against the DUT mid-cycle.
module tb_hazard_ctrl;

    logic CLK;
    logic RST_N;

    hazard_ctrl_if hif ();

    hazard_ctrl #(
        .BOOT_CYCLES (2),
        .MEM_TIMEOUT (4)
    ) u_dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .hif   (hif.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [11:0] exp_q [$];

    // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,ForwardAE,ForwardBE,MemErr}
    function automatic logic [11:0] mk(input logic sf, input logic sd, input logic se,
                                       input logic sm, input logic fd, input logic fe,
                                       input logic fw, input logic [1:0] fa,
                                       input logic [1:0] fb, input logic me);
        return {sf, sd, se, sm, fd, fe, fw, fa, fb, me};
    endfunction

    task automatic check_val(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%03h exp=%03h", tag, got, exp);
        end
    endtask

    task automatic clr_in();
        hif.Rs1D = '0; hif.Rs2D = '0; hif.Rs1E = '0; hif.Rs2E = '0; hif.RdE = '0;
        hif.ResultSrcE = '0; hif.PCSrcE = 1'b0; hif.RdM = '0; hif.RdW = '0;
        hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0;
        hif.MemReqM = 1'b0; hif.MemReadyM = 1'b0;
    endtask

    task automatic nxt();
        @(negedge CLK);
        clr_in();
    endtask

    // Queue the expectation for the inputs just driven, then sample and score.
    task automatic cyc(input string tag, input logic [11:0] exp);
        logic [11:0] obs;
        logic [11:0] want;
        exp_q.push_back(exp);
        #2;
        obs = {hif.StallF, hif.StallD, hif.StallE, hif.StallM, hif.FlushD, hif.FlushE,
               hif.FlushW, hif.ForwardAE, hif.ForwardBE, hif.MemErr};
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s scoreboard empty got=%03h", tag, obs);
        end else begin
            want = exp_q.pop_front();
            check_val(tag, obs, want);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] e_boot, e_idle, e_lu, e_br, e_wait, e_halt;
        e_boot = mk(1,0,0,0,1,1,0,2'b00,2'b00,0);
        e_idle = '0;
        e_lu   = mk(1,1,0,0,0,1,0,2'b00,2'b00,0);
        e_br   = mk(0,0,0,0,1,1,0,2'b00,2'b00,0);
        e_wait = mk(1,1,1,1,0,0,1,2'b00,2'b00,0);
        e_halt = mk(1,1,1,1,0,0,1,2'b00,2'b00,1);

        RST_N = 1'b0;
        clr_in();
        nxt(); cyc("rst_low0", e_boot);
        nxt(); cyc("rst_low1", e_boot);

        nxt(); RST_N = 1'b1; cyc("boot0", e_boot);
        nxt(); cyc("boot1", e_boot);
        nxt(); cyc("run_idle", e_idle);

        nxt(); hif.ResultSrcE = 3'b001; hif.RdE = 5'd5; hif.Rs2D = 5'd5;
        cyc("lu_rs2", e_lu);
        nxt(); cyc("lu_clear", e_idle);
        nxt(); hif.ResultSrcE = 3'b001; hif.RdE = 5'd0; hif.Rs2D = 5'd0;
        cyc("lu_x0", e_idle);
        nxt(); hif.ResultSrcE = 3'b001; hif.RdE = 5'd9; hif.Rs1D = 5'd9; hif.Rs2D = 5'd3;
        cyc("lu_rs1", e_lu);
        nxt(); hif.ResultSrcE = 3'b000; hif.RdE = 5'd9; hif.Rs1D = 5'd9;
        cyc("no_load", e_idle);

        nxt(); hif.PCSrcE = 1'b1; hif.ResultSrcE = 3'b001; hif.RdE = 5'd5; hif.Rs1D = 5'd5;
        cyc("br_over_lu", e_br);

        nxt(); hif.RdM = 5'd7; hif.RdW = 5'd7; hif.RegWriteM = 1'b1; hif.RegWriteW = 1'b1;
        hif.Rs1E = 5'd7;
        cyc("fwd_a_m", mk(0,0,0,0,0,0,0,2'b10,2'b00,0));
        nxt(); hif.RdM = 5'd7; hif.RdW = 5'd7; hif.RegWriteW = 1'b1; hif.Rs1E = 5'd7;
        cyc("fwd_a_w", mk(0,0,0,0,0,0,0,2'b01,2'b00,0));
        nxt(); hif.RdM = 5'd7; hif.RdW = 5'd7; hif.RegWriteM = 1'b1; hif.RegWriteW = 1'b1;
        hif.Rs2E = 5'd7; hif.Rs1E = 5'd2;
        cyc("fwd_b_m", mk(0,0,0,0,0,0,0,2'b00,2'b10,0));
        nxt(); hif.RdM = 5'd7; hif.RdW = 5'd7; hif.RegWriteW = 1'b1; hif.Rs2E = 5'd7;
        cyc("fwd_b_w", mk(0,0,0,0,0,0,0,2'b00,2'b01,0));
        nxt(); hif.RdM = 5'd0; hif.RdW = 5'd0; hif.RegWriteM = 1'b1; hif.RegWriteW = 1'b1;
        cyc("fwd_x0", e_idle);

        nxt(); hif.MemReqM = 1'b1; cyc("wait1", e_wait);
        nxt(); hif.MemReqM = 1'b1; hif.PCSrcE = 1'b1; cyc("wait2_br", e_wait);
        nxt(); hif.MemReqM = 1'b1; hif.RegWriteM = 1'b1; hif.RdM = 5'd7; hif.Rs1E = 5'd7;
        cyc("wait3_fwd", mk(1,1,1,1,0,0,1,2'b10,2'b00,0));
        nxt(); hif.MemReqM = 1'b1; hif.MemReadyM = 1'b1; cyc("ready", e_idle);
        nxt(); hif.MemReqM = 1'b1; cyc("rewait1", e_wait);
        nxt(); hif.MemReqM = 1'b1; cyc("rewait2", e_wait);
        nxt(); hif.MemReqM = 1'b1; cyc("rewait3", e_wait);
        nxt(); hif.MemReqM = 1'b1; hif.MemReadyM = 1'b1; cyc("reready", e_idle);
        nxt(); cyc("post_wait", e_idle);

        for (int i = 0; i < 4; i++) begin
            nxt(); hif.MemReqM = 1'b1;
            cyc($sformatf("to_wait%0d", i + 1), e_wait);
        end
        nxt(); hif.MemReqM = 1'b1; hif.MemReadyM = 1'b1; hif.PCSrcE = 1'b1;
        hif.RegWriteM = 1'b1; hif.RdM = 5'd4; hif.Rs1E = 5'd4;
        cyc("halt0", e_halt);
        nxt(); cyc("halt1", e_halt);

        nxt(); RST_N = 1'b0; cyc("halt_rst", mk(1,0,0,0,1,1,0,2'b00,2'b00,1));
        nxt(); RST_N = 1'b1; hif.RegWriteM = 1'b1; hif.RdM = 5'd4; hif.Rs1E = 5'd4;
        cyc("reboot0", e_boot);
        nxt(); hif.RegWriteW = 1'b1; hif.RdW = 5'd6; hif.Rs2E = 5'd6;
        cyc("reboot1", e_boot);
        nxt(); cyc("rerun", e_idle);

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL leftover_expectations got=%0d exp=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and flush controller for the 5-stage RV32 core. It is the producer of the clear/stall controls that the fetch, decode, execute and memory stage registers consume. It generates stage stalls, decode/execute flushes and execute-stage operand forwarding selects. It also sequences a post-reset pipeline purge and watches the data-memory handshake, halting the pipe if a memory access never completes.

## Interface
Parameters:
- BOOT_CYCLES, 2 — cycles after reset release during which the pipe is held and purged (≥1).
- MEM_TIMEOUT, 255 — max consecutive memory wait cycles before halt (≥1). Counter width = $clog2(MEM_TIMEOUT+1).

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  reset; one clock, synchronous, active-low.
- Rs1D, Rs2D  in  5 each  decode-stage source registers.
- Rs1E, Rs2E, RdE  in  5 each  execute-stage sources/destination.
- ResultSrcE  in  3  execute result select; 3'b001 = load.
- PCSrcE  in  1  branch/jump taken in execute.
- RdM, RdW  in  5 each  memory/writeback destinations.
- RegWriteM, RegWriteW  in  1 each  register write enables in M/W.
- MemReqM  in  1  load/store active in M.
- MemReadyM  in  1  data memory completes the access this cycle.
- StallF, StallD, StallE, StallM  out  1 each  hold the PC / F-D / D-E / E-M registers.
- FlushD, FlushE, FlushW  out  1 each  clear the F-D / D-E / M-W registers (E clear drives the D-E CLR input).
- ForwardAE, ForwardBE  out  2 each  operand select: 00 register file, 01 W result, 10 M ALU result.
- MemErr  out  1  sticky memory timeout flag.

## Operation
- State: BOOT, RUN, HALT. Also boot counter bcnt and wait counter wcnt.
- Reset (RST_N=0 at a CLK edge): state←BOOT, bcnt←0, wcnt←0, MemErr←0.
- All stall/flush/forward outputs are combinational from state plus inputs. With RST_N low they read StallF=1, FlushD=1, FlushE=1, all others 0.
- BOOT:
  - StallF=FlushD=FlushE=1; other stalls, FlushW and forwards are 0.
  - bcnt increments each cycle.
  - When bcnt==BOOT_CYCLES-1: next state RUN, bcnt←0.
- RUN, evaluated in priority order (first match wins):
  1. Memory wait (MemReqM & ~MemReadyM):
     - StallF=StallD=StallE=StallM=1, FlushW=1.
     - FlushD=FlushE=0; PCSrcE is ignored because E is held.
     - wcnt increments. If wcnt==MEM_TIMEOUT-1 while waiting: next state HALT, MemErr←1.
  2. Taken branch (PCSrcE=1):
     - FlushD=FlushE=1, StallF=StallD=0. The taken branch overrides load-use: the D instruction is wrong-path.
  3. Load-use (ResultSrcE==3'b001, RdE≠0, RdE==Rs1D or RdE==Rs2D):
     - StallF=StallD=1, FlushE=1.
  4. Otherwise all stalls and flushes are 0.
- wcnt←0 on any cycle that is not a memory wait, including the cycle MemReadyM rises.
- Forwarding, RUN only (forced 00 in BOOT/HALT):
  - ForwardAE=10 if RegWriteM & RdM≠0 & RdM==Rs1E.
  - Else 01 if RegWriteW & RdW≠0 & RdW==Rs1E.
  - Else 00.
  - M has priority over W. ForwardBE is identical using Rs2E.
  - Forwarding stays active during a memory wait.
- HALT: StallF=StallD=StallE=StallM=1, FlushW=1, no flushes, MemErr=1. Exit only via reset.

## Timing
- Hazard outputs have zero latency: the same cycle as the inputs.
- State, counters and MemErr update on the CLK rising edge.
- BOOT lasts exactly BOOT_CYCLES cycles after the first edge with RST_N=1. RUN behaviour starts on the following cycle.
- Load-use stall is 1 cycle: next cycle the load is in M and the FlushE bubble is in E, so the condition clears.
- Memory wait of N cycles (N<MEM_TIMEOUT) yields exactly N stalled cycles. The pipe advances in the cycle MemReadyM=1.
- Timeout: the MEM_TIMEOUT-th consecutive wait cycle is the last RUN cycle; HALT and MemErr=1 appear on the next cycle.
- Reset mid-wait or in HALT: the next cycle is BOOT, with wcnt=0 and MemErr=0.

## Test plan
- Reset, release RST_N: 2 cycles of StallF=FlushD=FlushE=1, then cycle 3 all 0 with no hazards present.
- Load-use: ResultSrcE=001, RdE=5, Rs2D=5 → StallF=StallD=FlushE=1 for one cycle. Repeat with RdE=0 → no stall.
- Branch with load-use in the same cycle: PCSrcE=1 plus load-use match → FlushD=FlushE=1, StallF=StallD=0.
- Forwarding: RdM=RdW=7, RegWriteM=RegWriteW=1, Rs1E=7 → ForwardAE=10. With RegWriteM=0 → 01. With Rs2E=7 → ForwardBE follows the same rule.
- Memory wait: MemReqM=1 with MemReadyM low for 3 cycles → 3 cycles of all stalls plus FlushW. Assert PCSrcE during the wait → FlushD stays 0. Ready on cycle 4 → all stalls 0 and wcnt back to 0.
- Timeout with MEM_TIMEOUT=4: MemReqM=1, MemReadyM=0 held → HALT and MemErr=1 after cycle 4, all stalls held. A later MemReadyM has no effect. RST_N pulse → BOOT and MemErr=0.
